// File: rtl/au_wb_skid_buffer.sv
// Two-entry in-order result buffer between the arithmetic unit and writeback.
// Accept-to-output latency is 1 cycle; in_ready is registered (not-full), so writeback stalls never reach execute combinationally.
module au_wb_skid_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  wdata_au,
  input  logic                   wen_au,
  input  logic [RADDR_WIDTH-1:0] rd_in,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [DATA_WIDTH-1:0]  wb_wdata,
  output logic                   wb_wen,
  output logic [RADDR_WIDTH-1:0] wb_rd,
  input  logic [RADDR_WIDTH-1:0] fwd_hit_rd,
  output logic                   fwd_hit,
  output logic [DATA_WIDTH-1:0]  fwd_data,
  output logic [1:0]             occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic                   head, head_nxt;
  logic                   ready_q;
  logic [DATA_WIDTH-1:0]  data_q [2];
  logic [1:0]             wen_q;
  logic [RADDR_WIDTH-1:0] rd_q [2];

  logic accept;
  logic dequeue;
  logic tail;

  assign accept  = in_valid & ready_q & ~flush;
  assign dequeue = (state != EMPTY) & wb_ready & ~flush;
  // Tail is head+count mod 2; only meaningful in EMPTY/ONE, where accept is possible.
  assign tail    = head ^ (state == ONE);

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    if (flush) begin
      state_nxt = EMPTY;
      head_nxt  = 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) state_nxt = ONE;
        end
        ONE: begin
          if (dequeue) head_nxt = ~head;
          if (accept && !dequeue)      state_nxt = FULL;
          else if (!accept && dequeue) state_nxt = EMPTY;
        end
        FULL: begin
          if (dequeue) begin
            state_nxt = ONE;
            head_nxt  = ~head;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= EMPTY;
      head      <= 1'b0;
      ready_q   <= 1'b0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      wen_q     <= '0;
      rd_q[0]   <= '0;
      rd_q[1]   <= '0;
    end else begin
      state   <= state_nxt;
      head    <= head_nxt;
      ready_q <= (state_nxt != FULL);
      if (accept) begin
        data_q[tail] <= wdata_au;
        wen_q[tail]  <= wen_au & (rd_in != '0);
        rd_q[tail]   <= rd_in;
      end
    end
  end

  assign in_ready  = ready_q;
  assign occupancy = state;
  assign wb_valid  = (state != EMPTY);
  assign wb_wdata  = wb_valid ? data_q[head] : '0;
  assign wb_wen    = wb_valid & wen_q[head];
  assign wb_rd     = wb_valid ? rd_q[head] : '0;

  // Older entry is checked first so the younger one overrides it.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_hit_rd != '0) begin
      if (state != EMPTY && wen_q[head] && rd_q[head] == fwd_hit_rd) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head];
      end
      if (state == FULL && wen_q[~head] && rd_q[~head] == fwd_hit_rd) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[~head];
      end
    end
  end

endmodule

// File: tb/tb_au_wb_skid_buffer.sv
// Directed bench for au_wb_skid_buffer; inputs change 1ns after the rising edge, outputs checked before the next edge.
module tb_au_wb_skid_buffer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] wdata_au = '0;
  logic        wen_au = 1'b0;
  logic [4:0]  rd_in = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_wdata;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [4:0]  fwd_hit_rd = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [1:0]  occupancy;

  int tests = 0;
  int fails = 0;

  au_wb_skid_buffer #(.DATA_WIDTH(32), .RADDR_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wdata_au(wdata_au), .wen_au(wen_au), .rd_in(rd_in),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wdata(wb_wdata), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .fwd_hit_rd(fwd_hit_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic w, input logic [4:0] r);
    in_valid = v;
    wdata_au = d;
    wen_au   = w;
    rd_in    = r;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({in_ready, wb_valid, wb_wen, wb_wdata, wb_rd, fwd_hit, fwd_data, occupancy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b v=%b occ=%0d want all 0", in_ready, wb_valid, occupancy);
    end
    step();
    RST = 1'b0;
    #2;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge got %b want 0", in_ready);
    end
    step();
    tests++;
    if (in_ready !== 1'b1 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL ready_after_release got rdy=%b occ=%0d want 1/0", in_ready, occupancy);
    end
    // Fill two entries, then reset asynchronously between edges.
    wb_ready = 1'b0;
    drive(1'b1, 32'h1, 1'b1, 5'd1);
    step();
    drive(1'b1, 32'h2, 1'b1, 5'd2);
    step();
    drive(1'b0, 32'h0, 1'b0, 5'd0);
    tests++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL prefill got occ=%0d rdy=%b want 2/0", occupancy, in_ready);
    end
    fwd_hit_rd = 5'd2;
    #2;
    RST = 1'b1;
    #1;
    tests++;
    if ({in_ready, wb_valid, wb_wen, wb_wdata, wb_rd, fwd_hit, fwd_data, occupancy} !== '0) begin
      fails++;
      $display("FAIL async_reset got rdy=%b v=%b d=%h hit=%b occ=%0d want all 0",
               in_ready, wb_valid, wb_wdata, fwd_hit, occupancy);
    end
    #2;
    RST = 1'b0;
    fwd_hit_rd = 5'd0;
    step();
    tests++;
    if (in_ready !== 1'b1 || occupancy !== 2'd0 || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release got rdy=%b occ=%0d v=%b want 1/0/0", in_ready, occupancy, wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h10 + 32'(i), 1'b1, 5'(i + 1));
      step();
      tests++;
      if (wb_valid !== 1'b1 || wb_wdata !== 32'h10 + 32'(i) || wb_rd !== 5'(i + 1) ||
          wb_wen !== 1'b1 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream[%0d] got v=%b d=%h rd=%0d occ=%0d rdy=%b want 1/%h/%0d/1/1",
                 i, wb_valid, wb_wdata, wb_rd, occupancy, in_ready, 32'h10 + 32'(i), i + 1);
      end
    end
    drive(1'b0, 32'h0, 1'b0, 5'd0);
    step();
    tests++;
    if (occupancy !== 2'd0 || wb_valid !== 1'b0 || wb_wdata !== 32'h0) begin
      fails++;
      $display("FAIL stream_drain got occ=%0d v=%b d=%h want 0/0/0", occupancy, wb_valid, wb_wdata);
    end
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b1, 5'd1);
    step();
    drive(1'b1, 32'hB, 1'b1, 5'd2);
    step();
    tests++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || wb_wdata !== 32'hA) begin
      fails++;
      $display("FAIL bp_full got occ=%0d rdy=%b d=%h want 2/0/a", occupancy, in_ready, wb_wdata);
    end
    drive(1'b1, 32'hC, 1'b1, 5'd3);
    step();
    tests++;
    if (occupancy !== 2'd2 || wb_wdata !== 32'hA || wb_rd !== 5'd1) begin
      fails++;
      $display("FAIL bp_hold got occ=%0d d=%h rd=%0d want 2/a/1", occupancy, wb_wdata, wb_rd);
    end
    drive(1'b0, 32'h0, 1'b0, 5'd0);
    wb_ready = 1'b1;
    step();
    tests++;
    if (occupancy !== 2'd1 || wb_wdata !== 32'hB || wb_rd !== 5'd2 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_drain1 got occ=%0d d=%h rd=%0d rdy=%b want 1/b/2/1", occupancy, wb_wdata, wb_rd, in_ready);
    end
    step();
    tests++;
    if (occupancy !== 2'd0 || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain2 got occ=%0d v=%b want 0/0 (0xC must not appear)", occupancy, wb_valid);
    end
  endtask

  task automatic test_wrap();
    // Leave head at 1: one push into slot 0, then drain it.
    wb_ready = 1'b0;
    drive(1'b1, 32'hEE, 1'b1, 5'd9);
    step();
    drive(1'b0, 32'h0, 1'b0, 5'd0);
    wb_ready = 1'b1;
    step();
    drive(1'b1, 32'h30, 1'b1, 5'd3);
    step();
    tests++;
    if (occupancy !== 2'd1 || wb_wdata !== 32'h30) begin
      fails++;
      $display("FAIL wrap_first got occ=%0d d=%h want 1/30", occupancy, wb_wdata);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'h30 + 32'(i), 1'b1, 5'(3 + i));
      step();
      tests++;
      if (occupancy !== 2'd1 || wb_wdata !== 32'h30 + 32'(i) || wb_rd !== 5'(3 + i)) begin
        fails++;
        $display("FAIL wrap[%0d] got occ=%0d d=%h rd=%0d want 1/%h/%0d",
                 i, occupancy, wb_wdata, wb_rd, 32'h30 + 32'(i), 3 + i);
      end
    end
    drive(1'b0, 32'h0, 1'b0, 5'd0);
    step();
    tests++;
    if (occupancy !== 2'd0 || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL wrap_drain got occ=%0d v=%b want 0/0", occupancy, wb_valid);
    end
  endtask

  task automatic test_rd0_forwarding();
    wb_ready = 1'b0;
    fwd_hit_rd = 5'd0;
    drive(1'b1, 32'h55, 1'b1, 5'd0);
    step();
    drive(1'b0, 32'h0, 1'b0, 5'd0);
    tests++;
    if (wb_valid !== 1'b1 || wb_wen !== 1'b0 || wb_wdata !== 32'h55 || fwd_hit !== 1'b0) begin
      fails++;
      $display("FAIL rd0 got v=%b wen=%b d=%h hit=%b want 1/0/55/0", wb_valid, wb_wen, wb_wdata, fwd_hit);
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    fwd_hit_rd = 5'd5;
    drive(1'b1, 32'h11, 1'b1, 5'd5);
    #1;
    tests++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      fails++;
      $display("FAIL fwd_unstored got hit=%b d=%h want 0/0", fwd_hit, fwd_data);
    end
    step();
    drive(1'b1, 32'h22, 1'b1, 5'd5);
    #1;
    tests++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h11) begin
      fails++;
      $display("FAIL fwd_older got hit=%b d=%h want 1/11", fwd_hit, fwd_data);
    end
    step();
    drive(1'b0, 32'h0, 1'b0, 5'd0);
    tests++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h22 || occupancy !== 2'd2) begin
      fails++;
      $display("FAIL fwd_younger got hit=%b d=%h occ=%0d want 1/22/2", fwd_hit, fwd_data, occupancy);
    end
    fwd_hit_rd = 5'd6;
    #1;
    tests++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      fails++;
      $display("FAIL fwd_miss got hit=%b d=%h want 0/0", fwd_hit, fwd_data);
    end
  endtask

  task automatic test_flush();
    // Buffer is FULL here from the forwarding scenario.
    drive(1'b1, 32'h99, 1'b1, 5'd7);
    wb_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 5'd0);
    tests++;
    if (occupancy !== 2'd0 || wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush got occ=%0d v=%b rdy=%b want 0/0/1", occupancy, wb_valid, in_ready);
    end
    step();
    tests++;
    if (occupancy !== 2'd0 || wb_valid !== 1'b0 || wb_wdata !== 32'h0) begin
      fails++;
      $display("FAIL flush_drop got occ=%0d v=%b d=%h want 0/0/0", occupancy, wb_valid, wb_wdata);
    end
    drive(1'b1, 32'h77, 1'b1, 5'd4);
    step();
    drive(1'b0, 32'h0, 1'b0, 5'd0);
    tests++;
    if (occupancy !== 2'd1 || wb_wdata !== 32'h77 || wb_rd !== 5'd4) begin
      fails++;
      $display("FAIL post_flush got occ=%0d d=%h rd=%0d want 1/77/4", occupancy, wb_wdata, wb_rd);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_rd0_forwarding();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
